// File: rtl/z80_bus_arbiter.sv
// z80_bus_arbiter: shares one async-read / sync-write 8-bit RAM between the
// Z80 CPU (stalled via clock enable), a video fetcher and a DMA engine.
// Video has priority over DMA; a stall counter periodically forces a CPU
// cycle so the CPU is never denied for more than CPU_MAX_STALL cycles.
module z80_bus_arbiter #(
  parameter int unsigned CPU_MAX_STALL = 4
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [15:0] cpu_address,
  input  logic        cpu_we,
  input  logic [7:0]  cpu_data_o,
  output logic [7:0]  cpu_data_i,
  output logic        cpu_ce,
  input  logic        vid_req,
  input  logic [15:0] vid_address,
  output logic        vid_gnt,
  output logic        vid_valid,
  output logic [7:0]  vid_data,
  input  logic        dma_req,
  input  logic        dma_we,
  input  logic [15:0] dma_address,
  input  logic [7:0]  dma_wdata,
  output logic        dma_gnt,
  output logic        dma_valid,
  output logic [7:0]  dma_rdata,
  output logic [15:0] mem_address,
  output logic        mem_we,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata
);

  localparam logic [3:0] STALL_LIMIT = 4'(CPU_MAX_STALL);

  typedef enum logic [1:0] {
    OWNER_CPU = 2'd0,
    OWNER_VID = 2'd1,
    OWNER_DMA = 2'd2
  } owner_t;

  owner_t     owner_s;
  logic [3:0] stall_cnt_r;

  // CPU data comes straight from the asynchronous RAM in its own cycle.
  assign cpu_data_i = mem_rdata;

  // Choose this cycle's bus owner: forced CPU at the stall limit, else VID > DMA > CPU.
  always_comb begin
    owner_s = OWNER_CPU;
    if (stall_cnt_r >= STALL_LIMIT) begin
      owner_s = OWNER_CPU;
    end else if (vid_req) begin
      owner_s = OWNER_VID;
    end else if (dma_req) begin
      owner_s = OWNER_DMA;
    end else begin
      owner_s = OWNER_CPU;
    end
  end

  // Drive grants and route the owner's access to the RAM; all enables held off in reset.
  always_comb begin
    mem_address = cpu_address;
    mem_we      = 1'b0;
    mem_wdata   = cpu_data_o;
    cpu_ce      = 1'b0;
    vid_gnt     = 1'b0;
    dma_gnt     = 1'b0;
    if (!reset_n) begin
      mem_address = cpu_address;
    end else begin
      case (owner_s)
        OWNER_CPU: begin
          mem_we = cpu_we;
          cpu_ce = 1'b1;
        end
        OWNER_VID: begin
          mem_address = vid_address;
          vid_gnt     = 1'b1;
        end
        OWNER_DMA: begin
          mem_address = dma_address;
          mem_we      = dma_we;
          mem_wdata   = dma_wdata;
          dma_gnt     = 1'b1;
        end
        default: begin
          mem_address = cpu_address;
        end
      endcase
    end
  end

  // Count consecutive cycles the CPU has been denied; any CPU cycle restarts the count.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stall_cnt_r <= 4'd0;
    end else if (owner_s == OWNER_CPU) begin
      stall_cnt_r <= 4'd0;
    end else begin
      stall_cnt_r <= stall_cnt_r + 4'd1;
    end
  end

  // Capture read data for video and DMA reads, valid exactly one cycle after the grant.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      vid_valid <= 1'b0;
      vid_data  <= 8'h00;
      dma_valid <= 1'b0;
      dma_rdata <= 8'h00;
    end else begin
      vid_valid <= vid_gnt;
      dma_valid <= dma_gnt & ~dma_we;
      if (vid_gnt) begin
        vid_data <= mem_rdata;
      end
      if (dma_gnt && !dma_we) begin
        dma_rdata <= mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_z80_bus_arbiter.sv
// Directed testbench for z80_bus_arbiter with a behavioural async-read RAM.
// Inputs change on the falling edge; outputs are checked 1 time unit later.
module tb_z80_bus_arbiter;

  logic        clock;
  logic        reset_n;
  logic [15:0] cpu_address;
  logic        cpu_we;
  logic [7:0]  cpu_data_o;
  logic [7:0]  cpu_data_i;
  logic        cpu_ce;
  logic        vid_req;
  logic [15:0] vid_address;
  logic        vid_gnt;
  logic        vid_valid;
  logic [7:0]  vid_data;
  logic        dma_req;
  logic        dma_we;
  logic [15:0] dma_address;
  logic [7:0]  dma_wdata;
  logic        dma_gnt;
  logic        dma_valid;
  logic [7:0]  dma_rdata;
  logic [15:0] mem_address;
  logic        mem_we;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;

  logic [7:0]  ram [0:65535];

  int n_checks = 0;
  int n_fail   = 0;

  z80_bus_arbiter #(.CPU_MAX_STALL(4)) dut (
    .clock(clock), .reset_n(reset_n),
    .cpu_address(cpu_address), .cpu_we(cpu_we), .cpu_data_o(cpu_data_o),
    .cpu_data_i(cpu_data_i), .cpu_ce(cpu_ce),
    .vid_req(vid_req), .vid_address(vid_address), .vid_gnt(vid_gnt),
    .vid_valid(vid_valid), .vid_data(vid_data),
    .dma_req(dma_req), .dma_we(dma_we), .dma_address(dma_address),
    .dma_wdata(dma_wdata), .dma_gnt(dma_gnt), .dma_valid(dma_valid),
    .dma_rdata(dma_rdata),
    .mem_address(mem_address), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  assign mem_rdata = ram[mem_address];

  always @(posedge clock) begin
    if (mem_we) ram[mem_address] <= mem_wdata;
  end

  // Advance to the next falling edge and settle.
  task automatic step();
    @(negedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; cpu_address = 16'h0100; cpu_we = 1'b1; cpu_data_o = 8'h11;
    vid_req = 1'b1; vid_address = 16'h4000; dma_req = 1'b1; dma_we = 1'b1;
    dma_address = 16'h3000; dma_wdata = 8'h22;
    step();
    n_checks++; if (cpu_ce !== 1'b0) begin n_fail++; $display("FAIL rst_cpu_ce got %b exp 0", cpu_ce); end
    n_checks++; if (vid_gnt !== 1'b0 || dma_gnt !== 1'b0) begin n_fail++; $display("FAIL rst_gnt got %b%b exp 00", vid_gnt, dma_gnt); end
    n_checks++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL rst_mem_we got %b exp 0", mem_we); end
    n_checks++; if (mem_address !== 16'h0100) begin n_fail++; $display("FAIL rst_mem_addr got %h exp 0100", mem_address); end
    n_checks++; if ({vid_valid, dma_valid, vid_data, dma_rdata} !== 18'd0) begin n_fail++; $display("FAIL rst_regs got %b %b %h %h exp zeros", vid_valid, dma_valid, vid_data, dma_rdata); end
    @(negedge clock);
    reset_n = 1'b1; cpu_we = 1'b0; vid_req = 1'b0; dma_req = 1'b0; dma_we = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++; if (cpu_ce !== 1'b1 || mem_address !== 16'h0100) begin n_fail++; $display("FAIL idle_cpu cyc %0d got ce=%b addr=%h exp ce=1 addr=0100", i, cpu_ce, mem_address); end
      n_checks++; if (vid_valid !== 1'b0 || dma_valid !== 1'b0) begin n_fail++; $display("FAIL idle_valid cyc %0d got %b%b exp 00", i, vid_valid, dma_valid); end
      @(negedge clock);
    end
  endtask

  task automatic test_vid_single();
    vid_req = 1'b1; vid_address = 16'h4000;
    #1;
    n_checks++; if (vid_gnt !== 1'b1 || cpu_ce !== 1'b0) begin n_fail++; $display("FAIL vid1_gnt got gnt=%b ce=%b exp gnt=1 ce=0", vid_gnt, cpu_ce); end
    n_checks++; if (mem_address !== 16'h4000 || mem_we !== 1'b0) begin n_fail++; $display("FAIL vid1_mem got addr=%h we=%b exp 4000 0", mem_address, mem_we); end
    @(negedge clock); vid_req = 1'b0; #1;
    n_checks++; if (vid_valid !== 1'b1 || vid_data !== 8'h5A) begin n_fail++; $display("FAIL vid1_data got v=%b d=%h exp v=1 d=5a", vid_valid, vid_data); end
    n_checks++; if (cpu_ce !== 1'b1) begin n_fail++; $display("FAIL vid1_cpu_back got %b exp 1", cpu_ce); end
    step();
    n_checks++; if (vid_valid !== 1'b0) begin n_fail++; $display("FAIL vid1_valid_drop got %b exp 0", vid_valid); end
  endtask

  task automatic test_vid_burst();
    logic prev_gnt;
    logic exp_ce;
    prev_gnt = 1'b0;
    @(negedge clock); vid_req = 1'b1; vid_address = 16'h4000;
    for (int i = 0; i < 10; i++) begin
      #1;
      exp_ce = ((i % 5) == 4) ? 1'b1 : 1'b0;
      n_checks++; if (cpu_ce !== exp_ce || vid_gnt !== ~exp_ce) begin n_fail++; $display("FAIL burst cyc %0d got ce=%b gnt=%b exp ce=%b gnt=%b", i, cpu_ce, vid_gnt, exp_ce, ~exp_ce); end
      n_checks++; if (vid_valid !== prev_gnt) begin n_fail++; $display("FAIL burst_valid cyc %0d got %b exp %b", i, vid_valid, prev_gnt); end
      prev_gnt = ~exp_ce;
      @(negedge clock);
    end
    vid_req = 1'b0;
  endtask

  task automatic test_vid_dma();
    vid_req = 1'b1; vid_address = 16'h4000;
    dma_req = 1'b1; dma_we = 1'b1; dma_address = 16'h1234; dma_wdata = 8'hA5;
    cpu_address = 16'h0100; cpu_we = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      n_checks++; if (vid_gnt !== 1'b1 || dma_gnt !== 1'b0) begin n_fail++; $display("FAIL vd_vid beat %0d got v=%b d=%b exp v=1 d=0", i, vid_gnt, dma_gnt); end
      @(negedge clock);
    end
    vid_req = 1'b0; #1;
    n_checks++; if (dma_gnt !== 1'b1 || cpu_ce !== 1'b0 || mem_we !== 1'b1) begin n_fail++; $display("FAIL vd_dma got gnt=%b ce=%b we=%b exp 1 0 1", dma_gnt, cpu_ce, mem_we); end
    n_checks++; if (mem_address !== 16'h1234 || mem_wdata !== 8'hA5) begin n_fail++; $display("FAIL vd_dma_bus got %h/%h exp 1234/a5", mem_address, mem_wdata); end
    @(negedge clock); dma_req = 1'b0; cpu_address = 16'h1234; #1;
    n_checks++; if (cpu_ce !== 1'b1 || cpu_data_i !== 8'hA5) begin n_fail++; $display("FAIL vd_cpu_read got ce=%b d=%h exp 1 a5", cpu_ce, cpu_data_i); end
    n_checks++; if (dma_valid !== 1'b0) begin n_fail++; $display("FAIL vd_dma_valid got %b exp 0", dma_valid); end
    @(negedge clock);
  endtask

  task automatic test_cpu_write_during_dma();
    cpu_address = 16'h2000; cpu_we = 1'b1; cpu_data_o = 8'h77;
    dma_req = 1'b1; dma_we = 1'b0; dma_address = 16'h4000;
    #1;
    n_checks++; if (dma_gnt !== 1'b1 || cpu_ce !== 1'b0 || mem_we !== 1'b0 || mem_address !== 16'h4000) begin n_fail++; $display("FAIL cw_dma got gnt=%b ce=%b we=%b a=%h exp 1 0 0 4000", dma_gnt, cpu_ce, mem_we, mem_address); end
    @(negedge clock); dma_req = 1'b0; #1;
    n_checks++; if (ram[16'h2000] !== 8'h00) begin n_fail++; $display("FAIL cw_early_write got %h exp 00", ram[16'h2000]); end
    n_checks++; if (dma_valid !== 1'b1 || dma_rdata !== 8'h5A) begin n_fail++; $display("FAIL cw_dma_read got v=%b d=%h exp 1 5a", dma_valid, dma_rdata); end
    n_checks++; if (cpu_ce !== 1'b1 || mem_we !== 1'b1 || mem_address !== 16'h2000 || mem_wdata !== 8'h77) begin n_fail++; $display("FAIL cw_cpu got ce=%b we=%b a=%h d=%h exp 1 1 2000 77", cpu_ce, mem_we, mem_address, mem_wdata); end
    @(negedge clock); cpu_we = 1'b0; #1;
    n_checks++; if (ram[16'h2000] !== 8'h77 || dma_valid !== 1'b0) begin n_fail++; $display("FAIL cw_done got ram=%h v=%b exp 77 0", ram[16'h2000], dma_valid); end
    @(negedge clock);
  endtask

  task automatic test_forced_cpu_priority();
    logic [1:0] exp_own [0:5];
    exp_own[0] = 2'd1; exp_own[1] = 2'd1; exp_own[2] = 2'd1;
    exp_own[3] = 2'd1; exp_own[4] = 2'd0; exp_own[5] = 2'd1;
    vid_req = 1'b1; dma_req = 1'b1; dma_we = 1'b0; cpu_address = 16'h0100;
    for (int i = 0; i < 6; i++) begin
      #1;
      n_checks++; if (cpu_ce !== (exp_own[i] == 2'd0) || vid_gnt !== (exp_own[i] == 2'd1) || dma_gnt !== 1'b0) begin n_fail++; $display("FAIL prio cyc %0d got ce=%b v=%b d=%b exp own=%0d", i, cpu_ce, vid_gnt, dma_gnt, exp_own[i]); end
      @(negedge clock);
    end
    vid_req = 1'b0; dma_req = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_reset_mid_grant();
    vid_req = 1'b1; vid_address = 16'h4000;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++; if (vid_gnt !== 1'b1) begin n_fail++; $display("FAIL rmg_pre cyc %0d got %b exp 1", i, vid_gnt); end
      @(negedge clock);
    end
    #1;
    n_checks++; if (vid_gnt !== 1'b1 || vid_valid !== 1'b1) begin n_fail++; $display("FAIL rmg_grant got gnt=%b v=%b exp 1 1", vid_gnt, vid_valid); end
    #1 reset_n = 1'b0;
    #1;
    n_checks++; if (vid_valid !== 1'b0 || vid_gnt !== 1'b0 || cpu_ce !== 1'b0) begin n_fail++; $display("FAIL rmg_in_rst got v=%b g=%b ce=%b exp 0 0 0", vid_valid, vid_gnt, cpu_ce); end
    step();
    n_checks++; if (vid_valid !== 1'b0) begin n_fail++; $display("FAIL rmg_next got %b exp 0", vid_valid); end
    #1 reset_n = 1'b1;
    #1;
    for (int i = 0; i < 5; i++) begin
      n_checks++; if (cpu_ce !== (i == 4) || vid_gnt !== (i != 4)) begin n_fail++; $display("FAIL rmg_post cyc %0d got ce=%b g=%b exp ce=%b", i, cpu_ce, vid_gnt, (i == 4)); end
      step();
    end
    vid_req = 1'b0;
    step();
    n_checks++; if (cpu_ce !== 1'b1) begin n_fail++; $display("FAIL rmg_idle got %b exp 1", cpu_ce); end
  endtask

  initial begin
    for (int a = 0; a < 65536; a++) ram[a] = 8'h00;
    ram[16'h4000] = 8'h5A;
    @(negedge clock);
    test_reset();
    test_vid_single();
    test_vid_burst();
    test_vid_dma();
    test_cpu_write_during_dma();
    test_forced_cpu_priority();
    test_reset_mid_grant();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
